// File: rtl/bcd_convert_arbiter.sv
// rtl/bcd_convert_arbiter.sv - round-robin arbitrated binary-to-BCD converter
// One double-dabble iteration per clock; the result is held until the consumer takes it.
module bcd_convert_arbiter #(
  parameter int WIDTH  = 16,
  parameter int NREQ   = 4,
  parameter int DIGITS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WIDTH-1:0]      req_bin,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [4*DIGITS-1:0]        rsp_bcd,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, RESPOND} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       cnt;
  logic [IDW-1:0]      last_grant;
  logic [WIDTH-1:0]    shift;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_shift;
  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_idx;
  logic                found;
  logic                accept;
  logic                last_iter;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

  always_comb begin
    for (int d = 0; d < DIGITS; d++) begin
      bcd_adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
    end
    bcd_shift = {bcd_adj[4*DIGITS-2:0], shift[WIDTH-1]};
  end

  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign accept    = (state == IDLE) && found;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = rst ? '0 : grant;
        if (found) state_next = CONVERT;
      end
      CONVERT: begin
        if (last_iter) state_next = RESPOND;
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // rsp_bcd is a separate register so the previous result survives a new conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      last_grant <= IDW'(NREQ - 1);
      rsp_id     <= '0;
      rsp_bcd    <= '0;
      shift      <= '0;
      bcd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift      <= req_bin[grant_idx*WIDTH +: WIDTH];
            bcd        <= '0;
            cnt        <= '0;
            rsp_id     <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        CONVERT: begin
          bcd   <= bcd_shift;
          shift <= shift << 1;
          cnt   <= cnt + CW'(1);
          if (last_iter) rsp_bcd <= bcd_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb/tb_bcd_convert_arbiter.sv - scoreboard bench for bcd_convert_arbiter
// Stimulus queues hand-computed results; the monitor checks every response and handshake.
module tb_bcd_convert_arbiter;

  localparam int WIDTH  = 16;
  localparam int NREQ   = 4;
  localparam int DIGITS = 5;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_bin;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [4*DIGITS-1:0]   rsp_bcd;
  logic                  busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [19:0] bcd;
  } exp_t;

  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_q = 1'b0;
  logic done = 1'b0;

  bcd_convert_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_bcd(rsp_bcd), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, between active edges.
  int          acc_edge = 0;
  logic        prev_valid = 1'b0;
  logic        hold = 1'b0;
  logic        post_hs = 1'b0;
  logic [19:0] prev_bcd = '0;
  logic [1:0]  prev_id = '0;
  logic [19:0] last_bcd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_bcd", 32'(rsp_bcd), 32'd0);
      chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      if (rst) chk("reset_req_ready", 32'(req_ready), 32'd0);
      hold    = 1'b0;
      post_hs = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) chk("latency", 32'(cyc - acc_edge), 32'(WIDTH));
      if (rsp_valid) begin
        chk("respond_req_ready", 32'(req_ready), 32'd0);
        chk("respond_busy", 32'(busy), 32'd1);
      end
      if (hold) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_bcd", 32'(rsp_bcd), 32'(prev_bcd));
        chk("hold_id", 32'(rsp_id), 32'(prev_id));
      end
      if (post_hs) begin
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_retain", 32'(rsp_bcd), 32'(last_bcd));
        if (req_valid != '0) chk("post_hs_grant_ready", 32'(req_ready != '0), 32'd1);
      end
      post_hs = 1'b0;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_bcd), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_bcd", 32'(rsp_bcd), 32'(e.bcd));
          last_bcd = e.bcd;
        end
        post_hs = 1'b1;
      end
      if ((req_valid & req_ready) != '0) begin
        chk("grant_onehot", 32'($onehot(req_ready)), 32'd1);
        acc_edge = cyc + 1;
      end
      hold     = rsp_valid && !rsp_ready;
      prev_bcd = rsp_bcd;
      prev_id  = rsp_id;
    end
    prev_valid = rsp_valid;
    if (done) begin
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [1:0] id, input logic [19:0] bcd);
    exp_t e;
    e.id  = id;
    e.bcd = bcd;
    exp_q.push_back(e);
  endtask

  task automatic single(input int id, input logic [15:0] val, input logic [19:0] bcd);
    expect_rsp(2'(id), bcd);
    req_bin[id*WIDTH +: WIDTH] = val;
    req_valid[id] = 1'b1;
    tick(1);
    req_valid = '0;
    tick(20);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_bin   = '0;
    rsp_ready = 1'b1;
    tick(3);
    rst       = 1'b0;
    req_valid = '0;
    tick(2);

    single(0, 16'd23456, 20'h23456);
    single(0, 16'd12623, 20'h12623);
    single(0, 16'd0,     20'h00000);
    single(0, 16'd65535, 20'h65535);

    // All four requesters contend after a fresh reset.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    expect_rsp(2'd0, 20'h00001);
    expect_rsp(2'd1, 20'h00099);
    expect_rsp(2'd2, 20'h04096);
    expect_rsp(2'd3, 20'h50000);
    req_bin   = {16'd50000, 16'd4096, 16'd99, 16'd1};
    req_valid = 4'b1111;
    tick(60);
    req_valid = '0;
    tick(20);
    expect_rsp(2'd0, 20'h00777);
    expect_rsp(2'd2, 20'h31415);
    req_bin[0*WIDTH +: WIDTH] = 16'd777;
    req_bin[2*WIDTH +: WIDTH] = 16'd31415;
    req_valid = 4'b0101;
    tick(25);
    req_valid = '0;
    tick(20);

    // Consumer stalls five cycles while requester 1 waits.
    rsp_ready = 1'b0;
    expect_rsp(2'd0, 20'h09999);
    expect_rsp(2'd1, 20'h00321);
    req_bin[0*WIDTH +: WIDTH] = 16'd9999;
    req_bin[1*WIDTH +: WIDTH] = 16'd321;
    req_valid = 4'b0001;
    tick(1);
    req_valid = 4'b0010;
    tick(21);
    rsp_ready = 1'b1;
    tick(2);
    req_valid = '0;
    tick(20);

    // Reset during iteration 8 drops the operation.
    req_bin[0*WIDTH +: WIDTH] = 16'd42;
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(20);
    expect_rsp(2'd0, 20'h01000);
    req_bin[0*WIDTH +: WIDTH] = 16'd1000;
    req_bin[3*WIDTH +: WIDTH] = 16'd5;
    req_valid = 4'b1001;
    tick(1);
    req_valid = '0;
    tick(20);

    // Single-cycle pulse, operand changes after capture.
    expect_rsp(2'd1, 20'h60001);
    req_bin[1*WIDTH +: WIDTH] = 16'd60001;
    req_valid = 4'b0010;
    tick(1);
    req_valid = '0;
    req_bin[1*WIDTH +: WIDTH] = 16'd11111;
    tick(3);
    req_bin[1*WIDTH +: WIDTH] = 16'd222;
    tick(20);

    done = 1'b1;
  end

endmodule
